// File: rtl/data_memory_ctrl.sv
// Single-port data memory with valid/ready requests, byte-enabled writes,
// a pipelined read path of RD_LAT registers and an optional post-reset clear.
module data_memory_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_e;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                clr_we_s;
  logic                in_range_s;
  logic                acc_s, wr_s, rd_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [RD_LAT-1:0]   vld_q;
  logic [RD_LAT-1:0]   err_q;
  logic [DATA_W-1:0]   dat_q [RD_LAT];

  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full
      assign in_range_s = 1'b1;
    end else begin : g_part
      assign in_range_s = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
    end
  endgenerate

  assign acc_s = req_valid & ready_q;
  assign wr_s  = acc_s & req_we & in_range_s;
  assign rd_s  = acc_s & ~req_we;

  // State, clear counter and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: walk the clear counter to the last word, then run forever
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST_C) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end else begin
          state_d   = CLEAR;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  // Output decode; flags are computed from the next state so the registers line up
  always_comb begin
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    clr_we_s = 1'b0;
    case (state_d)
      RUN:     ready_d = 1'b1;
      CLEAR:   busy_d  = 1'b1;
      default: busy_d  = 1'b0;
    endcase
    if ((state_q == CLEAR) && !rst) begin
      clr_we_s = 1'b1;
    end else begin
      clr_we_s = 1'b0;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem_q[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word_s = '0;
    if (in_range_s) begin
      rd_word_s = mem_q[req_addr];
    end else begin
      rd_word_s = '0;
    end
  end

  // Read pipeline; data/err stages only load on a valid so the tail holds its value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_s;
      if (rd_s) begin
        dat_q[0] <= rd_word_s;
        err_q[0] <= ~in_range_s;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_err   = err_q[RD_LAT-1];
  assign rsp_rdata = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl using three instances: default (A),
// DEPTH=20/RD_LAT=3 (B) and RD_LAT=2 (C, reset mid-operation).
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        vld_a, vld_b, vld_c;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rdy_a, rv_a, err_a, busy_a;
  logic        rdy_b, rv_b, err_b, busy_b;
  logic        rdy_c, rv_c, err_c, busy_c;
  logic [31:0] rd_a, rd_b, rd_c;

  int checks = 0;
  int failures = 0;

  data_memory_ctrl #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst(rst_a), .req_valid(vld_a), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a), .busy(busy_a));

  data_memory_ctrl #(.DATA_W(32), .DEPTH(20), .ADDR_W(5), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst(rst_b), .req_valid(vld_b), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b), .busy(busy_b));

  data_memory_ctrl #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_c (
    .clk(clk), .rst(rst_c), .req_valid(vld_c), .req_ready(rdy_c), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_c), .rsp_rdata(rd_c), .rsp_err(err_c), .busy(busy_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    vld_a     = (sel == 0);
    vld_b     = (sel == 1);
    vld_c     = (sel == 2);
  endtask

  task automatic idle;
    vld_a = 1'b0;
    vld_b = 1'b0;
    vld_c = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(sel, 1'b1, a, d, be);
    tick();
    idle();
  endtask

  task automatic test_reset;
    int  cnt;
    bit  rdy_seen;
    checks++;
    if (rdy_a !== 1'b0 || rv_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b busy=%b, required 0 0 00000000 0 1",
               rdy_a, rv_a, rd_a, err_a, busy_a);
    end
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    cnt = 0;
    rdy_seen = 1'b0;
    while (busy_a === 1'b1 && cnt < 100) begin
      if (rdy_a !== 1'b0) rdy_seen = 1'b1;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 32) begin
      failures++;
      $display("FAIL clear_cycles: busy high for %0d cycles, required 32", cnt);
    end
    checks++;
    if (rdy_seen) begin
      failures++;
      $display("FAIL ready_during_clear: ready seen 1, required 0 throughout clear");
    end
    checks++;
    if (rdy_a !== 1'b1 || busy_a !== 1'b0 || rdy_b !== 1'b1 || busy_b !== 1'b0 || rdy_c !== 1'b1) begin
      failures++;
      $display("FAIL run_after_clear: readyA=%b busyA=%b readyB=%b busyB=%b readyC=%b, required 1 0 1 0 1",
               rdy_a, busy_a, rdy_b, busy_b, rdy_c);
    end
  endtask

  task automatic test_cleared_contents;
    for (int i = 0; i < 32; i++) begin
      drive(0, 1'b0, 5'(i), 32'h0, 4'h0);
      tick();
      checks++;
      if (rv_a !== 1'b1 || rd_a !== 32'h0 || err_a !== 1'b0) begin
        failures++;
        $display("FAIL cleared_word[%0d]: valid=%b rdata=%h err=%b, required 1 00000000 0", i, rv_a, rd_a, err_a);
      end
    end
    idle();
  endtask

  task automatic test_byte_enable;
    wr(0, 5'd5, 32'hAABBCCDD, 4'b1111);
    checks++;
    if (rv_a !== 1'b0) begin
      failures++;
      $display("FAIL write_no_response: valid=%b, required 0", rv_a);
    end
    wr(0, 5'd5, 32'h11223344, 4'b0101);
    drive(0, 1'b0, 5'd5, 32'h0, 4'h0);
    tick();
    idle();
    checks++;
    if (rv_a !== 1'b1 || rd_a !== 32'hAA22CC44 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL byte_enable: valid=%b rdata=%h err=%b, required 1 aa22cc44 0", rv_a, rd_a, err_a);
    end
    tick();
    checks++;
    if (rv_a !== 1'b0 || rd_a !== 32'hAA22CC44) begin
      failures++;
      $display("FAIL rsp_hold: valid=%b rdata=%h, required 0 aa22cc44", rv_a, rd_a);
    end
    wr(0, 5'd5, 32'hFFFFFFFF, 4'b0000);
    drive(0, 1'b0, 5'd5, 32'h0, 4'h0);
    tick();
    idle();
    checks++;
    if (rv_a !== 1'b1 || rd_a !== 32'hAA22CC44) begin
      failures++;
      $display("FAIL be_zero_noop: valid=%b rdata=%h, required 1 aa22cc44", rv_a, rd_a);
    end
  endtask

  task automatic test_read_after_write;
    drive(0, 1'b1, 5'd7, 32'hDEADBEEF, 4'hF);
    tick();
    drive(0, 1'b0, 5'd7, 32'h0, 4'h0);
    tick();
    idle();
    checks++;
    if (rv_a !== 1'b1 || rd_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_after_write: valid=%b rdata=%h, required 1 deadbeef", rv_a, rd_a);
    end
  endtask

  task automatic test_pipeline;
    logic        exp_v;
    logic [31:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      wr(1, 5'(i), 32'h10 + 32'(i), 4'hF);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) drive(1, 1'b0, 5'(k - 1), 32'h0, 4'h0);
      else if (k == 5) drive(1, 1'b1, 5'd10, 32'h99, 4'hF);
      else idle();
      tick();
      exp_v = (k >= 3 && k <= 6);
      exp_d = 32'h10 + 32'(k - 3);
      checks++;
      if (rv_b !== exp_v || (exp_v && (rd_b !== exp_d || err_b !== 1'b0))) begin
        failures++;
        $display("FAIL pipeline_cycle%0d: valid=%b rdata=%h err=%b, required %b %h 0", k, rv_b, rd_b, err_b, exp_v, exp_d);
      end
    end
    idle();
  endtask

  task automatic test_out_of_range;
    logic [31:0] exp_d;
    wr(1, 5'd25, 32'h55, 4'hF);
    wr(1, 5'd19, 32'h1919, 4'hF);
    drive(1, 1'b0, 5'd25, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (rv_b !== 1'b1 || rd_b !== 32'h0 || err_b !== 1'b1) begin
      failures++;
      $display("FAIL oor_read: valid=%b rdata=%h err=%b, required 1 00000000 1", rv_b, rd_b, err_b);
    end
    for (int i = 19; i >= 0; i--) begin
      if (i < 4) exp_d = 32'h10 + 32'(i);
      else if (i == 10) exp_d = 32'h99;
      else if (i == 19) exp_d = 32'h1919;
      else exp_d = 32'h0;
      drive(1, 1'b0, 5'(i), 32'h0, 4'h0);
      tick();
      idle();
      tick();
      tick();
      checks++;
      if (rv_b !== 1'b1 || rd_b !== exp_d || err_b !== 1'b0) begin
        failures++;
        $display("FAIL oor_word[%0d]: valid=%b rdata=%h err=%b, required 1 %h 0", i, rv_b, rd_b, err_b, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    bit v_seen;
    bit rdy_seen;
    wr(2, 5'd1, 32'h77, 4'hF);
    wr(2, 5'd2, 32'h88, 4'hF);
    drive(2, 1'b0, 5'd1, 32'h0, 4'h0);
    tick();
    drive(2, 1'b0, 5'd2, 32'h0, 4'h0);
    tick();
    idle();
    rst_c = 1'b1;
    #1;
    checks++;
    if (rv_c !== 1'b0 || rd_c !== 32'h0 || err_c !== 1'b0 || rdy_c !== 1'b0 || busy_c !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_values: valid=%b rdata=%h err=%b ready=%b busy=%b, required 0 00000000 0 0 1",
               rv_c, rd_c, err_c, rdy_c, busy_c);
    end
    v_seen = 1'b0;
    drive(2, 1'b1, 5'd3, 32'h12345678, 4'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rv_c !== 1'b0) v_seen = 1'b1;
    end
    idle();
    rst_c = 1'b0;
    cnt = 0;
    rdy_seen = 1'b0;
    while (busy_c === 1'b1 && cnt < 100) begin
      if (rdy_c !== 1'b0) rdy_seen = 1'b1;
      if (rv_c !== 1'b0) v_seen = 1'b1;
      cnt++;
      tick();
    end
    checks++;
    if (v_seen) begin
      failures++;
      $display("FAIL inflight_discard: rsp_valid seen 1, required 0 through reset and clear");
    end
    checks++;
    if (cnt != 32 || rdy_seen || rdy_c !== 1'b1) begin
      failures++;
      $display("FAIL clear_restart: busy cycles=%0d ready_during=%b ready_end=%b, required 32 0 1", cnt, rdy_seen, rdy_c);
    end
    drive(2, 1'b0, 5'd1, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (rv_c !== 1'b1 || rd_c !== 32'h0 || err_c !== 1'b0) begin
      failures++;
      $display("FAIL recleared_word: valid=%b rdata=%h err=%b, required 1 00000000 0", rv_c, rd_c, err_c);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    idle();
    drive(3, 1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    #1;
    test_reset();
    test_cleared_contents();
    test_byte_enable();
    test_read_after_write();
    test_pipeline();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised single-port data memory with a valid/ready request interface, per-byte write strobes, a configurable pipelined read latency and an optional post-reset clearing sequence. It replaces the fixed 32×32 combinational-select data memory in the CPU datapath. It is the load/store target of the memory stage, which issues one request per cycle and consumes read responses without backpressure.

## Interface
Parameters:
- DATA_W, 32, data word width; must be a multiple of 8
- DEPTH, 32, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 5, word-address width
- RD_LAT, 1, read latency in cycles; legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  read data valid, one-cycle pulse per read
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  qualified by rsp_valid; 1 = read address ≥ DEPTH
- busy  out  1  clearing sequence in progress

## Operation
- FSM states: CLEAR, RUN.
- Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=CLEAR_ON_RESET, clear counter=0, read pipeline empty.
- CLEAR behaviour:
  - One word zeroed per cycle, at counter addresses 0..DEPTH-1.
  - req_ready=0 and busy=1 throughout.
  - After writing word DEPTH-1: transition to RUN, busy=0, req_ready=1.
- RUN: req_ready=1 every cycle. A request is accepted when req_valid && req_ready.
- Write:
  - Only bytes with req_be[i]=1 are updated; other bytes are unchanged.
  - req_be=0 is a legal no-op.
  - A write to an address ≥ DEPTH is dropped silently.
  - Writes produce no response.
- Read:
  - The address is captured at acceptance.
  - rsp_valid pulses exactly RD_LAT cycles later with the word's contents.
  - Reads are fully pipelined: back-to-back reads yield back-to-back responses in issue order.
  - A read of an address ≥ DEPTH returns rsp_rdata=0, rsp_err=1.
- Read-after-write: a read accepted in any cycle after a write's acceptance observes the written data.
- Only one request per cycle, so there are no same-cycle collisions.
- Outside response cycles, rsp_valid=0. rsp_rdata and rsp_err hold their last value.
- Memory contents are not reset by rst. With CLEAR_ON_RESET=0, contents persist across reset; with CLEAR_ON_RESET=1, they become zero after the clear sequence.

## Timing
- Clear duration: DEPTH cycles from the first rising edge after rst deasserts. First acceptance is possible on cycle DEPTH+1 (cycle 1 for CLEAR_ON_RESET=0).
- Read accepted at edge N gives rsp_valid high in the cycle following edge N+RD_LAT-1. Equivalently, RD_LAT=1 means data is registered on the acceptance edge, and each extra stage adds one register.
- Throughput is one request per cycle. Writes interleaved with reads do not disturb in-flight read responses.
- rst asserted mid-operation:
  - All outputs go to reset values immediately (asynchronous).
  - In-flight reads are discarded and never produce rsp_valid.
  - A write presented in the reset cycle is not performed.
  - An interrupted clear restarts from address 0.
- req_valid while req_ready=0 is ignored. The requester must hold or re-present the request.

## Test plan
- Reset and clear: DEPTH=32, CLEAR_ON_RESET=1, assert then release rst.
  - Required: busy=1 and req_ready=0 for exactly 32 cycles, then busy=0 and req_ready=1.
  - Reading addresses 0..31 returns 0x00000000 with rsp_err=0.
- Byte enables: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101, then read addr 5.
  - Required: rsp_rdata=0xAA22CC44.
- Latency and pipelining: RD_LAT=3, preload addrs 0..3 with 0x10..0x13, issue 4 back-to-back reads.
  - Required: rsp_valid high for 4 consecutive cycles starting 3 cycles after the first acceptance, with data 0x10, 0x11, 0x12, 0x13 in order.
- Read-after-write: write 0xDEADBEEF to addr 7 at cycle N, read addr 7 at N+1, RD_LAT=1.
  - Required: response 0xDEADBEEF at N+2.
- Out of range: DEPTH=20, ADDR_W=5; write 0x55 to addr 25, then read addr 25, then read addr 19.
  - Required: first read gives rsp_rdata=0, rsp_err=1; second gives stored value with rsp_err=0; no word in 0..19 is modified.
- Reset mid-operation: issue 2 reads with RD_LAT=2 and assert rst one cycle after the second acceptance.
  - Required: rsp_valid stays 0 and the clear restarts at address 0 (busy=1 for DEPTH cycles after release).
